// File: rtl/threshold_pkg.sv
// Shared widths, defaults and FSM state encoding for the threshold controller.
package threshold_pkg;

    localparam int BITS_DEF    = 8;
    localparam int MAX_BPM_DEF = 200;

    // Width needed to carry a BPM value in the range 0..max_bpm.
    function automatic int bpm_width(input int max_bpm);
        return $clog2(max_bpm + 1);
    endfunction

    // Width of the bpm * (2^bits - 1) product fed to the divider.
    function automatic int num_width(input int max_bpm, input int bits);
        return bpm_width(max_bpm) + bits;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/threshold_ctrl_seq_divider.sv
// Restoring divider by a fixed divisor, one quotient bit per clock.
// done is high during the final iteration; quotient is final the cycle after.
module seq_divider #(
    parameter int NUM_W   = 16,
    parameter int QUO_W   = 8,
    parameter int DIVISOR = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NUM_W-1:0] numerator,
    output logic             done,
    output logic [QUO_W-1:0] quotient
);

    // Shifted remainder can reach 2*DIVISOR-1; the stored remainder stays below DIVISOR.
    localparam int REM_W = $clog2(2 * DIVISOR);
    localparam int CNT_W = $clog2(NUM_W + 1);
    localparam logic [REM_W-1:0] DIV_V = REM_W'(DIVISOR);

    logic [NUM_W-1:0] dividend;
    logic [REM_W-2:0] rem;
    logic [REM_W-2:0] rem_nx;
    logic [REM_W-1:0] shifted;
    logic [QUO_W-1:0] quo;
    logic [CNT_W-1:0] count;
    logic             running;
    logic             fits;

    // One restoring step: bring in the next dividend bit and trial-subtract.
    always_comb begin
        shifted = {rem, dividend[NUM_W-1]};
        fits    = (shifted >= DIV_V);
        rem_nx  = fits ? (REM_W-1)'(shifted - DIV_V) : shifted[REM_W-2:0];
    end

    // Iteration registers; the down-counter terminates the divide after NUM_W steps.
    always_ff @(posedge clk) begin
        if (reset) begin
            dividend <= '0;
            rem      <= '0;
            quo      <= '0;
            count    <= '0;
            running  <= 1'b0;
        end else if (start) begin
            dividend <= numerator;
            rem      <= '0;
            quo      <= '0;
            count    <= CNT_W'(NUM_W);
            running  <= 1'b1;
        end else if (running) begin
            dividend <= {dividend[NUM_W-2:0], 1'b0};
            rem      <= rem_nx;
            quo      <= {quo[QUO_W-2:0], fits};
            count    <= count - 1'b1;
            if (count == CNT_W'(1)) begin
                running <= 1'b0;
            end
        end
    end

    assign done     = running && (count == CNT_W'(1));
    assign quotient = quo;

endmodule

// File: rtl/threshold_ctrl.sv
// Converts BPM estimates into a brightness threshold, applied only at frame boundaries.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for a captured BPM value
//   ST_LOAD   | consume pending value, start the divider with bpm*(2^BITS-1)
//   ST_DIVIDE | divider iterating, one quotient bit per cycle
//   ST_DONE   | write quotient into the staged register
module threshold_ctrl
    import threshold_pkg::*;
#(
    parameter int BITS    = BITS_DEF,
    parameter int MAX_BPM = MAX_BPM_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [bpm_width(MAX_BPM)-1:0]   bpm_in,
    input  logic                            bpm_valid,
    input  logic                            frame_start,
    input  logic                            filter_enable,
    output logic [BITS-1:0]                 threshold,
    output logic                            threshold_update,
    output logic                            busy,
    output logic                            bpm_clamped
);

    localparam int BPM_W = bpm_width(MAX_BPM);
    localparam int NUM_W = num_width(MAX_BPM, BITS);
    localparam logic [BPM_W-1:0] MAX_V  = BPM_W'(MAX_BPM);
    localparam logic [NUM_W-1:0] FULL_V = NUM_W'((2 ** BITS) - 1);

    state_t            state;
    state_t            state_nx;
    logic [BPM_W-1:0]  pend_bpm;
    logic              pending;
    logic              clamp_q;
    logic              div_start;
    logic              pend_clear;
    logic              stage_write;
    logic              div_done;
    logic [BITS-1:0]   div_quo;
    logic [NUM_W-1:0]  numerator;
    logic [BITS-1:0]   staged;
    logic              staged_valid;
    logic [BITS-1:0]   active;
    logic              en_q;
    logic              update_q;
    logic [BITS-1:0]   thr_now;
    logic [BITS-1:0]   thr_next;

    // Capture the latest BPM sample, clamped to full scale; a new sample overrides an unconsumed one.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_bpm <= '0;
            pending  <= 1'b0;
            clamp_q  <= 1'b0;
        end else begin
            clamp_q <= bpm_valid && (bpm_in > MAX_V);
            if (bpm_valid) begin
                pend_bpm <= (bpm_in > MAX_V) ? MAX_V : bpm_in;
                pending  <= 1'b1;
            end else if (pend_clear) begin
                pending  <= 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and sequencing strobes.
    always_comb begin
        state_nx    = state;
        div_start   = 1'b0;
        pend_clear  = 1'b0;
        stage_write = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pending) begin
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                div_start  = 1'b1;
                pend_clear = 1'b1;
                state_nx   = ST_DIVIDE;
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                stage_write = 1'b1;
                state_nx    = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Full-scale product: bpm * (2^BITS - 1), exact in NUM_W bits.
    assign numerator = NUM_W'(pend_bpm) * FULL_V;

    seq_divider #(
        .NUM_W   (NUM_W),
        .QUO_W   (BITS),
        .DIVISOR (MAX_BPM)
    ) u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .numerator (numerator),
        .done      (div_done),
        .quotient  (div_quo)
    );

    // Current and would-be thresholds; the frame boundary moves next into now.
    always_comb begin
        thr_now  = en_q ? active : '0;
        thr_next = '0;
        if (filter_enable) begin
            thr_next = staged_valid ? staged : active;
        end
    end

    // Staged/active registers. A DONE write coinciding with frame_start lands after the
    // old staged value has been promoted, so the fresh result waits for the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            staged       <= '0;
            staged_valid <= 1'b0;
            active       <= '0;
            en_q         <= 1'b0;
            update_q     <= 1'b0;
        end else begin
            update_q <= 1'b0;
            if (frame_start) begin
                en_q     <= filter_enable;
                update_q <= (thr_next != thr_now);
                if (staged_valid) begin
                    active <= staged;
                end
            end
            if (stage_write) begin
                staged       <= div_quo;
                staged_valid <= 1'b1;
            end else if (frame_start) begin
                staged_valid <= 1'b0;
            end
        end
    end

    // Outputs are forced low for as long as reset is held.
    assign threshold        = reset ? '0 : thr_now;
    assign threshold_update = !reset && update_q;
    assign busy             = !reset && (pending || (state != ST_IDLE));
    assign bpm_clamped      = !reset && clamp_q;

endmodule

// File: doc/threshold_ctrl.md
THRESHOLD_CTRL -- requirements
Module: threshold_ctrl

Interface
REQ-001 Parameter BITS, default 8, pixel/threshold width.
REQ-002 Parameter MAX_BPM, default 200, full-scale BPM; maps to threshold 2^BITS-1.
REQ-003 Derived widths: BPM_W = $clog2(MAX_BPM+1) (8 at default); NUM_W = BPM_W+BITS (16 at default).
REQ-004 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 Port reset, input, 1, synchronous, active-high.
REQ-006 Port bpm_in, input, BPM_W, new BPM estimate.
REQ-007 Port bpm_valid, input, 1, one-cycle qualifier for bpm_in.
REQ-008 Port frame_start, input, 1, one-cycle start-of-frame pulse.
REQ-009 Port filter_enable, input, 1, level; 0 makes the threshold filter transparent.
REQ-010 Port threshold, output, BITS, active brightness threshold for the filter datapath.
REQ-011 Port threshold_update, output, 1, one-cycle pulse when threshold changes value.
REQ-012 Port busy, output, 1, high while a computation is pending or in progress.
REQ-013 Port bpm_clamped, output, 1, one-cycle pulse when a sampled bpm_in exceeds MAX_BPM.

Function
REQ-014 On bpm_valid, bpm_in is captured into a pending register and pending_flag is set; a newer capture overwrites an unconsumed one (latest wins).
REQ-015 Captured values above MAX_BPM are clamped to MAX_BPM; bpm_clamped pulses the cycle after the sample.
REQ-016 FSM states: IDLE, LOAD, DIVIDE, DONE.
REQ-017 IDLE -> LOAD when pending_flag=1; LOAD clears pending_flag, latches numerator = bpm*(2^BITS-1) into NUM_W bits, and zeroes the quotient and remainder.
REQ-018 DIVIDE runs a restoring divide by MAX_BPM, one quotient bit per cycle for exactly NUM_W cycles, then -> DONE.
REQ-019 DONE writes quotient[BITS-1:0] into staged, sets staged_valid, and -> IDLE in one cycle.
REQ-020 Result is floor(bpm*(2^BITS-1)/MAX_BPM) with no truncation error; the quotient never exceeds 2^BITS-1 after clamping.
REQ-021 Latency: staged_valid is high exactly NUM_W+3 cycles after the bpm_valid sample edge (19 at default), given an idle FSM.
REQ-022 bpm_valid during LOAD/DIVIDE/DONE does not disturb the computation in flight; it is captured per REQ-014 and processed on the next IDLE pass.
REQ-023 On frame_start with staged_valid=1: active <= staged and staged_valid cleared; threshold_update pulses next cycle only if the active value changed.
REQ-024 frame_start in the same cycle as DONE uses the previous staged contents; the new result waits for the next frame_start.
REQ-025 frame_start with staged_valid=0 leaves active unchanged and does not pulse threshold_update.
REQ-026 threshold = filter_enable ? active : 0; a change of filter_enable takes effect at the next frame_start only (registered enable sampled at frame_start).
REQ-027 busy = pending_flag OR (state != IDLE).
REQ-028 threshold never changes mid-frame; it changes only in the cycle after frame_start.

Reset
REQ-029 reset sets state=IDLE, pending_flag=0, staged_valid=0, staged=0, active=0, and the registered enable to 0.
REQ-030 While reset is high: threshold=0, threshold_update=0, busy=0, bpm_clamped=0.
REQ-031 reset mid-DIVIDE aborts the divide; no result is staged, and the pending value is discarded.

Structure
REQ-032 Package threshold_pkg holds MAX_BPM and BITS defaults, the BPM_W/NUM_W width functions, and the state enum typedef.
REQ-033 The divider is a sub-module seq_divider (start, numerator, fixed divisor, done, quotient); threshold_ctrl holds capture, FSM sequencing, and the staged/active registers.

Verification
REQ-034 Reset, bpm_in=100 with valid, then frame_start after 20 cycles -> threshold=127 and one threshold_update pulse.
REQ-035 bpm_in=200 -> 255; bpm_in=0 -> 0; bpm_in=250 -> bpm_clamped pulse and threshold 255.
REQ-036 bpm 100, then bpm 40 at cycle 5 of DIVIDE -> staged 127, then 51; one frame_start after both are done -> threshold 51.
REQ-037 frame_start coincident with DONE -> threshold unchanged that frame; next frame_start applies the new value.
REQ-038 filter_enable=0 with active 127 -> threshold 0 from the next frame_start; re-enable -> 127 at the following frame_start.
REQ-039 reset asserted mid-DIVIDE -> all outputs 0 and busy=0; a subsequent frame_start gives no update.
